cga_sequencer: RTL and testbench
================================

CGA_SEQUENCER -- requirements
Module: cga_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  pixel/dot clock; the only clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port: hres_mode  input  1  high = 16-clk character period; low = 32-clk period.
REQ-004 SHALL have port: cpu_req  input  1  level request for a CPU VRAM access; held until cpu_done.
REQ-005 SHALL have port: clk_seq  output  5  free-running sequence count feeding the pixel stage.
REQ-006 SHALL have port: vram_read_char  output  1  one-cycle strobe that latches the char/even byte.
REQ-007 SHALL have port: vram_read_att  output  1  one-cycle strobe that latches the attr/odd byte.
REQ-008 SHALL have port: vram_a0  output  1  VRAM address bit 0: 0 for the char slot, 1 for the attr slot.
REQ-009 SHALL have port: charrom_read  output  1  one-cycle strobe for the character ROM lookup.
REQ-010 SHALL have port: disp_pipeline  output  1  one-cycle strobe that advances the attr/cursor/enable delay line.
REQ-011 SHALL have port: crtc_clk  output  1  one-cycle character-clock enable for the CRTC.
REQ-012 SHALL have port: cpu_grant  output  1  high while the CPU owns the VRAM bus.
REQ-013 SHALL have port: cpu_done  output  1  one-cycle pulse on the last cycle of a granted window.
REQ-014 SHALL have parameter: CPU_WIN_LEN, default 4, CPU window length in clocks (range 1..4).

Function
REQ-015 SHALL increment clk_seq by 1 every clk and wrap it from 31 to 0, independent of mode.
REQ-016 SHALL capture hres_mode into internal hres_q only on the cycle where clk_seq==31, so a mode change never splits a character period.
REQ-017 SHALL compute slot offset off = hres_q ? clk_seq[3:0] : clk_seq[4:0].
REQ-018 SHALL assert vram_read_char at off==2, with vram_a0=0 during that cycle.
REQ-019 SHALL assert vram_read_att at off==4, with vram_a0=1 during that cycle.
REQ-020 SHALL hold vram_a0 at 0 in all cycles other than off==4.
REQ-021 SHALL assert charrom_read at off==6.
REQ-022 SHALL assert disp_pipeline and crtc_clk together at the last offset of the period: 15 when hres_q=1, 31 when hres_q=0.
REQ-023 SHALL treat all strobes as registered outputs, asserted for exactly one clk per occurrence.
REQ-024 SHALL provide CPU windows starting at off==8 in both modes, plus a second window at off==24 when hres_q=0.
REQ-025 SHALL sample cpu_req at window start minus 1 (off==7 or off==23); if high, raise cpu_grant for CPU_WIN_LEN cycles from window start.
REQ-026 SHALL pulse cpu_done coincident with the final cpu_grant cycle.
REQ-027 SHALL complete a granted window in full even if cpu_req drops mid-window.
REQ-028 SHALL NOT grant a window when cpu_req is low at the sample point, and SHALL NOT grant retroactively later in that window.
REQ-029 SHALL never overlap cpu_grant with vram_read_char or vram_read_att.
REQ-030 SHALL let an in-flight window finish at its programmed length when a mode change lands at clk_seq==31.
REQ-031 SHALL implement the grant logic as an FSM with states IDLE, ARMED (request sampled) and GRANT (with down-counter); GRANT returns to IDLE after its final cycle.

Reset
REQ-032 SHALL, while reset is high, force clk_seq=0, hres_q=0, FSM=IDLE and every strobe, cpu_grant, cpu_done and vram_a0 to 0.
REQ-033 SHALL abort any window immediately when reset asserts mid-window, with no cpu_done pulse.
REQ-034 SHALL start the sequence at clk_seq=0 on the first clk after reset deasserts.

Structure
REQ-035 SHALL define slot-offset constants (2, 4, 6, 7, 8, 15, 23, 24, 31) and the FSM state encoding in shared package cga_pkg.
REQ-036 SHALL use one sub-module, cga_cpu_arb, containing the FSM and window counter; the sequencing counter and strobe decode stay in the top level.

Verification
REQ-037 SHALL verify: reset released, hres_mode=1 -> strobes char@2, att@4, rom@6, disp_pipeline/crtc_clk@15 and @31, repeating every 16 clks.
REQ-038 SHALL verify: hres_mode=0 -> single char@2, att@4, crtc_clk@31 per 32 clks; cpu_req held high -> two windows per period (8..11 and 24..27).
REQ-039 SHALL verify: cpu_req rising at off==8 -> no grant until the next window; grant 4 cycles, with cpu_done on the 4th.
REQ-040 SHALL verify: hres_mode toggled at clk_seq==10 -> cadence changes only after clk_seq==31.
REQ-041 SHALL verify: reset pulsed at off==9 during a grant -> cpu_grant=0 next cycle, no cpu_done, clk_seq=0.
REQ-042 SHALL verify: CPU_WIN_LEN=1, cpu_req held high -> a single-cycle cpu_grant coincident with cpu_done.

Source files
------------

// File: rtl/cga_pkg.sv
// Shared slot offsets and arbiter state encoding for the CGA video/CPU sequencer.
package cga_pkg;

    localparam logic [4:0] OFF_CHAR     = 5'd2;
    localparam logic [4:0] OFF_ATT      = 5'd4;
    localparam logic [4:0] OFF_ROM      = 5'd6;
    localparam logic [4:0] OFF_WIN_A    = 5'd8;
    localparam logic [4:0] OFF_WIN_B    = 5'd24;
    localparam logic [4:0] OFF_SAMPLE_A = OFF_WIN_A - 5'd1;
    localparam logic [4:0] OFF_SAMPLE_B = OFF_WIN_B - 5'd1;
    localparam logic [4:0] OFF_LAST_HI  = 5'd15;
    localparam logic [4:0] OFF_LAST_LO  = 5'd31;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ARMED = 2'd1,
        ARB_GRANT = 2'd2
    } arb_state_e;

    // In 16-clk mode the upper sequence bit is ignored, so the slot pattern repeats twice.
    function automatic logic [4:0] slot_off(input logic [4:0] seq, input logic hres);
        return hres ? {1'b0, seq[3:0]} : seq;
    endfunction

endpackage

// File: rtl/cga_cpu_arb.sv
// CPU VRAM window arbiter: arms one slot before a window, then grants a fixed-length window.
//   state     | meaning
//   ARB_IDLE  | waiting for the slot before a CPU window
//   ARB_ARMED | sample slot in progress; cpu_req decides the window
//   ARB_GRANT | CPU owns VRAM; cnt_q counts down remaining cycles
module cga_cpu_arb
    import cga_pkg::*;
#(
    parameter int CPU_WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic [4:0] off_nxt,
    input  logic       hres_nxt,
    output logic       cpu_grant,
    output logic       cpu_done
);

    localparam logic [1:0] LAST_CNT = 2'(CPU_WIN_LEN - 1);

    arb_state_e state_q;
    logic [1:0] cnt_q;
    logic       grant_q;
    logic       done_q;
    logic       sample_hit;

    assign sample_hit = (off_nxt == OFF_SAMPLE_A) || (!hres_nxt && off_nxt == OFF_SAMPLE_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= 2'd0;
            grant_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    grant_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (sample_hit) state_q <= ARB_ARMED;
                end
                ARB_ARMED: begin
                    if (cpu_req) begin
                        state_q <= ARB_GRANT;
                        cnt_q   <= LAST_CNT;
                        grant_q <= 1'b1;
                        done_q  <= (LAST_CNT == 2'd0);
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_GRANT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= ARB_IDLE;
                        grant_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - 2'd1;
                        done_q <= (cnt_q == 2'd1);
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_grant = grant_q;
    assign cpu_done  = done_q;

endmodule

// File: rtl/cga_sequencer.sv
// CGA VRAM/character sequencer: free-running 32-clk count, slot strobes and CPU windows.
// All strobes are decoded from next-cycle values so they line up with clk_seq.
module cga_sequencer
    import cga_pkg::*;
#(
    parameter int CPU_WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hres_mode,
    input  logic       cpu_req,
    output logic [4:0] clk_seq,
    output logic       vram_read_char,
    output logic       vram_read_att,
    output logic       vram_a0,
    output logic       charrom_read,
    output logic       disp_pipeline,
    output logic       crtc_clk,
    output logic       cpu_grant,
    output logic       cpu_done
);

    logic [4:0] seq_q, seq_d;
    logic       hres_q, hres_d;
    logic [4:0] off_d;
    logic       char_q, char_d;
    logic       att_q, att_d;
    logic       rom_q, rom_d;
    logic       last_q, last_d;

    always_comb begin
        seq_d  = seq_q + 5'd1;
        // Mode only switches at a period boundary so a character is never split.
        hres_d = (seq_q == OFF_LAST_LO) ? hres_mode : hres_q;
        off_d  = slot_off(seq_d, hres_d);
        char_d = (off_d == OFF_CHAR);
        att_d  = (off_d == OFF_ATT);
        rom_d  = (off_d == OFF_ROM);
        last_d = (off_d == (hres_d ? OFF_LAST_HI : OFF_LAST_LO));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q  <= 5'd0;
            hres_q <= 1'b0;
            char_q <= 1'b0;
            att_q  <= 1'b0;
            rom_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            hres_q <= hres_d;
            char_q <= char_d;
            att_q  <= att_d;
            rom_q  <= rom_d;
            last_q <= last_d;
        end
    end

    cga_cpu_arb #(
        .CPU_WIN_LEN (CPU_WIN_LEN)
    ) u_cpu_arb (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .off_nxt   (off_d),
        .hres_nxt  (hres_d),
        .cpu_grant (cpu_grant),
        .cpu_done  (cpu_done)
    );

    assign clk_seq        = seq_q;
    assign vram_read_char = char_q;
    assign vram_read_att  = att_q;
    assign vram_a0        = att_q;
    assign charrom_read   = rom_q;
    assign disp_pipeline  = last_q;
    assign crtc_clk       = last_q;

endmodule

// File: tb/tb_cga_sequencer.sv
// Randomized bench for cga_sequencer (window lengths 4 and 1) against a cycle-level slot model.
module tb_cga_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hres_mode = 1'b0;
    logic       cpu_req = 1'b0;

    logic [4:0] seq4, seq1;
    logic       ch4, at4, a04, rom4, dp4, cc4, gr4, dn4;
    logic       ch1, at1, a01, rom1, dp1, cc1, gr1, dn1;

    int err_cnt = 0;
    int chk_cnt = 0;

    int m_seq = 0;
    bit m_hres = 1'b0;
    int rem4 = 0;
    int rem1 = 0;

    always #5 clk = ~clk;

    cga_sequencer u_dut4 (
        .clk(clk), .reset(reset), .hres_mode(hres_mode), .cpu_req(cpu_req),
        .clk_seq(seq4), .vram_read_char(ch4), .vram_read_att(at4), .vram_a0(a04),
        .charrom_read(rom4), .disp_pipeline(dp4), .crtc_clk(cc4),
        .cpu_grant(gr4), .cpu_done(dn4)
    );

    cga_sequencer #(.CPU_WIN_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .hres_mode(hres_mode), .cpu_req(cpu_req),
        .clk_seq(seq1), .vram_read_char(ch1), .vram_read_att(at1), .vram_a0(a01),
        .charrom_read(rom1), .disp_pipeline(dp1), .crtc_clk(cc1),
        .cpu_grant(gr1), .cpu_done(dn1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        int prev_off;
        int off;
        bit samp;
        logic [7:0] exp_v4, exp_v1;
        bit e_char, e_att, e_rom, e_last;
        @(posedge clk);
        if (reset) begin
            m_seq = 0; m_hres = 1'b0; rem4 = 0; rem1 = 0;
        end else begin
            prev_off = m_hres ? (m_seq % 16) : m_seq;
            samp = cpu_req && (prev_off == 7 || (!m_hres && prev_off == 23));
            rem4 = samp ? 4 : (rem4 > 0 ? rem4 - 1 : 0);
            rem1 = samp ? 1 : (rem1 > 0 ? rem1 - 1 : 0);
            if (m_seq == 31) m_hres = hres_mode;
            m_seq = (m_seq + 1) % 32;
        end
        #1;
        off    = m_hres ? (m_seq % 16) : m_seq;
        e_char = (off == 2);
        e_att  = (off == 4);
        e_rom  = (off == 6);
        e_last = (off == (m_hres ? 15 : 31));
        exp_v4 = {e_char, e_att, e_att, e_rom, e_last, e_last, rem4 > 0, rem4 == 1};
        exp_v1 = {e_char, e_att, e_att, e_rom, e_last, e_last, rem1 > 0, rem1 == 1};
        check_val("seq_len4", 32'(seq4), 32'(m_seq));
        check_val("outs_len4", 32'({ch4, at4, a04, rom4, dp4, cc4, gr4, dn4}), 32'(exp_v4));
        check_val("seq_len1", 32'(seq1), 32'(m_seq));
        check_val("outs_len1", 32'({ch1, at1, a01, rom1, dp1, cc1, gr1, dn1}), 32'(exp_v1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Model sequence always advances, so this wait is bounded by one period.
    task automatic wait_seq(input int target);
        for (int i = 0; i < 40 && m_seq != target; i++) step();
        check_val("wait_seq", 32'(m_seq), 32'(target));
    endtask

    initial begin
        reset = 1'b1; hres_mode = 1'b1; cpu_req = 1'b0;
        run(3);
        reset = 1'b0;
        run(40);                         // hres_q still 0 until first wrap
        run(64);                         // 16-clk cadence

        hres_mode = 1'b0; cpu_req = 1'b1;
        run(100);                        // 32-clk cadence, two windows per period

        cpu_req = 1'b0;
        run(40);
        wait_seq(8);
        cpu_req = 1'b1;                  // too late for this window
        run(60);

        hres_mode = 1'b1;
        wait_seq(10);
        hres_mode = 1'b0;
        run(5);
        wait_seq(10);
        hres_mode = 1'b1;
        run(50);

        cpu_req = 1'b1;
        wait_seq(9);
        check_val("grant_before_reset", 32'(gr4), 32'd1);
        reset = 1'b1;
        step();
        check_val("grant_after_reset", 32'(gr4), 32'd0);
        check_val("done_after_reset", 32'(dn4), 32'd0);
        check_val("seq_after_reset", 32'(seq4), 32'd0);
        reset = 1'b0;
        run(40);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) hres_mode = ~hres_mode;
            if ($urandom_range(0, 5) == 0)  cpu_req = ~cpu_req;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        run(4);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
